// File: rtl/sha256_compress_stream_if.sv
// Stream bundle for sha256_compress_stream: schedule-word input stream and
// digest-word output stream. The mode_224 wire exists only when SHA224_EN is
// defined.
interface sha256_compress_stream_if #(
    parameter int unsigned UNROLL = 1
);
    logic                    w_valid;
    logic                    w_ready;
    logic [32*UNROLL-1:0]    w_data;
    logic                    blk_first;
    logic                    blk_last;
`ifdef SHA224_EN
    logic                    mode_224;
`endif
    logic                    h_valid;
    logic                    h_ready;
    logic [31:0]             h_data;
    logic                    h_last;

`ifdef SHA224_EN
    modport master (output w_valid, w_data, blk_first, blk_last, mode_224, h_ready,
                    input  w_ready, h_valid, h_data, h_last);
    modport slave  (input  w_valid, w_data, blk_first, blk_last, mode_224, h_ready,
                    output w_ready, h_valid, h_data, h_last);
`else
    modport master (output w_valid, w_data, blk_first, blk_last, h_ready,
                    input  w_ready, h_valid, h_data, h_last);
    modport slave  (input  w_valid, w_data, blk_first, blk_last, h_ready,
                    output w_ready, h_valid, h_data, h_last);
`endif
endinterface

// File: rtl/sha256_compress_stream.sv
// SHA-256 compression core: consumes W0..W63 over a valid/ready stream,
// UNROLL (1/2/4) rounds per beat, keeps a chaining hash register and streams
// the digest one word per handshake. SHA224_EN adds the SHA-224 IV and a
// 7-word digest selected by mode_224.
module sha256_compress_stream #(
    parameter int unsigned UNROLL = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    sha256_compress_stream_if.slave        bus,
    output logic                           busy
);
    localparam int unsigned T_W    = 7;
    localparam logic [T_W-1:0] LAST_T = T_W'(64 - UNROLL);

    typedef logic [31:0] vars_t [8];
    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL, ST_OUT} state_t;

    localparam vars_t IV256 = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam vars_t IV224 = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    // One SHA-256 round on working variables a..h (index 0..7)
    function automatic vars_t f_round(input vars_t v, input logic [31:0] k, input logic [31:0] w);
        vars_t       r;
        logic [31:0] s0, s1, ch, maj, t1, t2;
        s1  = {v[4][5:0], v[4][31:6]} ^ {v[4][10:0], v[4][31:11]} ^ {v[4][24:0], v[4][31:25]};
        ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
        t1  = v[7] + s1 + ch + k + w;
        s0  = {v[0][1:0], v[0][31:2]} ^ {v[0][12:0], v[0][31:13]} ^ {v[0][21:0], v[0][31:22]};
        maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
        t2  = s0 + maj;
        r[7] = v[6];
        r[6] = v[5];
        r[5] = v[4];
        r[4] = v[3] + t1;
        r[3] = v[2];
        r[2] = v[1];
        r[1] = v[0];
        r[0] = t1 + t2;
        return r;
    endfunction

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [T_W-1:0]  r_t;
    vars_t           r_h, r_v, w_init, w_chain, w_sum;
    logic            r_mode, r_last, w_mode_in;
    logic [2:0]      w_last_idx;
    logic            r_w_ready, r_h_valid, r_h_last, r_busy;
    logic [31:0]     r_h_data;

`ifdef SHA224_EN
    assign w_mode_in = bus.mode_224;
`else
    assign w_mode_in = 1'b0;
`endif
    assign w_last_idx = r_mode ? 3'd6 : 3'd7;

    // Round datapath: pick IV/H or a..h, then chain UNROLL rounds
    always_comb begin : p_rounds
        if (bus.blk_first) begin
            w_init = w_mode_in ? IV224 : IV256;
        end else begin
            w_init = r_h;
        end
        if (r_state == ST_IDLE) begin
            w_chain = w_init;
        end else begin
            w_chain = r_v;
        end
        for (int i = 0; i < int'(UNROLL); i++) begin
            w_chain = f_round(w_chain, K[6'(r_t + T_W'(i))], bus.w_data[32*i +: 32]);
        end
        for (int i = 0; i < 8; i++) begin
            w_sum[i] = r_h[i] + r_v[i];
        end
    end

    // Next-state and output-word index
    always_comb begin : p_fsm_nxt
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        unique case (r_state)
            ST_IDLE:  if (bus.w_valid) w_state_nxt = ST_ROUND;
            ST_ROUND: if (bus.w_valid && (r_t == LAST_T)) w_state_nxt = ST_FINAL;
            ST_FINAL: w_state_nxt = r_last ? ST_OUT : ST_IDLE;
            ST_OUT: begin
                if (bus.h_ready) begin
                    if (r_idx == w_last_idx) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and output-word index
    always_ff @(posedge clk) begin : p_fsm_reg
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Working variables, round counter and chaining hash
    always_ff @(posedge clk) begin : p_data
        if (rst) begin
            r_t    <= '0;
            r_h    <= IV256;
            r_v    <= IV256;
            r_mode <= 1'b0;
            r_last <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.w_valid) begin
                        r_v    <= w_chain;
                        r_t    <= T_W'(UNROLL);
                        r_last <= bus.blk_last;
                        if (bus.blk_first) begin
                            r_h    <= w_init;
                            r_mode <= w_mode_in;
                        end
                    end
                end
                ST_ROUND: begin
                    if (bus.w_valid) begin
                        r_v <= w_chain;
                        r_t <= (r_t == LAST_T) ? '0 : r_t + T_W'(UNROLL);
                    end
                end
                ST_FINAL: r_h <= w_sum;
                default: ;
            endcase
        end
    end

    // Registered handshake/status outputs, derived from next state
    always_ff @(posedge clk) begin : p_outs
        if (rst) begin
            r_w_ready <= 1'b1;
            r_h_valid <= 1'b0;
            r_h_last  <= 1'b0;
            r_h_data  <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_w_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ROUND);
            r_h_valid <= (w_state_nxt == ST_OUT);
            r_h_last  <= (w_state_nxt == ST_OUT) && (w_idx_nxt == w_last_idx);
            r_busy    <= (w_state_nxt != ST_IDLE);
            if (w_state_nxt != ST_OUT) begin
                r_h_data <= '0;
            end else if (r_state == ST_FINAL) begin
                r_h_data <= w_sum[w_idx_nxt];
            end else begin
                r_h_data <= r_h[w_idx_nxt];
            end
        end
    end

    assign bus.w_ready = r_w_ready;
    assign bus.h_valid = r_h_valid;
    assign bus.h_data  = r_h_data;
    assign bus.h_last  = r_h_last;
    assign busy        = r_busy;
endmodule

// File: tb/tb_sha256_compress_stream.sv
// Directed bench for sha256_compress_stream: "abc", two-block message, stalls,
// mid-block reset and (with SHA224_EN) SHA-224 "abc". Message schedules are
// expanded here; digests are the published FIPS 180-4 example values.
module tb_sha256_compress_stream #(
    parameter int unsigned UNROLL = 1
);
    localparam int NB = 64 / int'(UNROLL);

    typedef logic [31:0] dig_t [8];
    localparam dig_t EXP_ABC  = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                  32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam dig_t EXP_2BLK = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                  32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
`ifdef SHA224_EN
    localparam dig_t EXP_224  = '{32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
                                  32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};
`endif

    logic clk, rst, busy;
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;
    int   t_first, t_last;
    logic [31:0] msg   [3][16];
    logic [31:0] sched [3][64];

    sha256_compress_stream_if #(.UNROLL(UNROLL)) bus ();

    sha256_compress_stream #(.UNROLL(UNROLL)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic junk_data();
        for (int i = 0; i < int'(UNROLL); i++) bus.w_data[32*i +: 32] = $urandom;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_w_ready"}, 32'(bus.w_ready), 32'd1);
        chk({tag, "_h_valid"}, 32'(bus.h_valid), 32'd0);
        chk({tag, "_h_data"},  bus.h_data,       32'd0);
        chk({tag, "_h_last"},  32'(bus.h_last),  32'd0);
        chk({tag, "_busy"},    32'(busy),        32'd0);
    endtask

    // Checks the cycle after the last round beat (FINAL)
    task automatic check_final(input string tag);
        chk({tag, "_final_w_ready"}, 32'(bus.w_ready), 32'd0);
        chk({tag, "_final_h_valid"}, 32'(bus.h_valid), 32'd0);
        chk({tag, "_final_busy"},    32'(busy),        32'd1);
    endtask

    // Streams nbeats schedule beats; optional 3-cycle w_valid gaps at rounds 10 and 40
    task automatic send_block(input int blk, input bit first, input bit last, input bit m224,
                              input bit stall, input int nbeats);
        int g;
        int u;
        u = int'(UNROLL);
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            if (stall && ((b*u <= 10 && 10 < (b+1)*u) || (b*u <= 40 && 40 < (b+1)*u))) begin
                bus.w_valid = 1'b0;
                junk_data();
                repeat (3) @(negedge clk);
            end
            g = 0;
            while (!bus.w_ready && g < 200) begin
                @(negedge clk);
                g++;
            end
            chk("w_ready_beat", 32'(bus.w_ready), 32'd1);
            chk("h_valid_beat", 32'(bus.h_valid), 32'd0);
            bus.w_valid = 1'b1;
            for (int i = 0; i < u; i++) bus.w_data[32*i +: 32] = sched[blk][b*u + i];
            if (b == 0) begin
                bus.blk_first = first;
                bus.blk_last  = last;
`ifdef SHA224_EN
                bus.mode_224  = m224;
`endif
                t_first = cyc;
            end else begin
                bus.blk_first = 1'($urandom);
                bus.blk_last  = 1'($urandom);
`ifdef SHA224_EN
                bus.mode_224  = 1'($urandom);
`endif
            end
            t_last = cyc;
            @(posedge clk);
        end
        @(negedge clk);
        bus.w_valid = 1'b0;
        junk_data();
        if (!m224) begin
            bus.blk_first = 1'b0;
        end
    endtask

    // Drains the digest, optionally stalling h_ready for 5 cycles on one word
    task automatic collect(input string tag, input dig_t e, input int nw, input int stall_w,
                           input bit lat_chk);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus.h_valid && g < 200);
        chk({tag, "_h_valid_wait"}, 32'(bus.h_valid), 32'd1);
        if (lat_chk) chk({tag, "_latency"}, 32'(cyc - t_first), 32'(NB + 1));
        for (int w = 0; w < nw; w++) begin
            if (w > 0) @(negedge clk);
            chk($sformatf("%s_h_valid[%0d]", tag, w), 32'(bus.h_valid), 32'd1);
            chk($sformatf("%s_h_data[%0d]", tag, w), bus.h_data, e[w]);
            chk($sformatf("%s_h_last[%0d]", tag, w), 32'(bus.h_last), 32'(w == nw - 1));
            if (w == stall_w) begin
                bus.h_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk($sformatf("%s_stall_valid[%0d]", tag, w), 32'(bus.h_valid), 32'd1);
                    chk($sformatf("%s_stall_data[%0d]", tag, w), bus.h_data, e[w]);
                    chk($sformatf("%s_stall_last[%0d]", tag, w), 32'(bus.h_last), 32'(w == nw - 1));
                end
                bus.h_ready = 1'b1;
            end
        end
        @(negedge clk);
        check_idle({tag, "_drained"});
    endtask

    initial begin
        rst           = 1'b1;
        bus.w_valid   = 1'b0;
        bus.w_data    = '0;
        bus.blk_first = 1'b0;
        bus.blk_last  = 1'b0;
        bus.h_ready   = 1'b1;
`ifdef SHA224_EN
        bus.mode_224  = 1'b0;
`endif
        // Padded blocks: "abc", then the two blocks of the 448-bit message
        for (int b = 0; b < 3; b++) for (int i = 0; i < 16; i++) msg[b][i] = 32'h0;
        msg[0][0]  = 32'h61626380;
        msg[0][15] = 32'h00000018;
        for (int i = 0; i < 14; i++) begin
            msg[1][i] = {8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)};
        end
        msg[1][14] = 32'h80000000;
        msg[2][15] = 32'h000001c0;
        for (int b = 0; b < 3; b++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16) sched[b][t] = msg[b][t];
                else sched[b][t] = (rotr(sched[b][t-2], 17) ^ rotr(sched[b][t-2], 19) ^ (sched[b][t-2] >> 10))
                                 + sched[b][t-7]
                                 + (rotr(sched[b][t-15], 7) ^ rotr(sched[b][t-15], 18) ^ (sched[b][t-15] >> 3))
                                 + sched[b][t-16];
            end
        end

        repeat (2) @(negedge clk);
        check_idle("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_after");

        // "abc" single block
        send_block(0, 1'b1, 1'b1, 1'b0, 1'b0, NB);
        check_final("abc");
        collect("abc", EXP_ABC, 8, -1, 1'b1);

        // Two-block chained message, second block starts right after FINAL
        send_block(1, 1'b1, 1'b0, 1'b0, 1'b0, NB);
        check_final("blk1");
        t_last = t_last;
        begin
            int tl;
            tl = t_last;
            send_block(2, 1'b0, 1'b1, 1'b0, 1'b0, NB);
            chk("chain_gap", 32'(t_first - tl), 32'd2);
        end
        check_final("blk2");
        collect("two_blk", EXP_2BLK, 8, -1, 1'b1);

        // "abc" with input gaps and an output stall on word 3
        send_block(0, 1'b1, 1'b1, 1'b0, 1'b1, NB);
        check_final("stall");
        collect("stall", EXP_ABC, 8, 2, 1'b0);

`ifdef SHA224_EN
        send_block(0, 1'b1, 1'b1, 1'b1, 1'b0, NB);
        check_final("sha224");
        collect("sha224", EXP_224, 7, -1, 1'b1);
        bus.mode_224 = 1'b0;
`endif

        // Abort a chained block around round 30, then "abc" chaining from reset H
        send_block(0, 1'b0, 1'b1, 1'b0, 1'b0, (30 + int'(UNROLL) - 1) / int'(UNROLL));
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_mid_after");
        send_block(0, 1'b0, 1'b1, 1'b0, 1'b0, NB);
        check_final("post_rst");
        collect("post_rst", EXP_ABC, 8, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sha256_compress_stream.md
# sha256_compress_stream

Parametrised successor to the single-block message compression stage. It consumes the 64 message-schedule words W0..W63 from the expansion stage over a valid/ready stream and keeps a chaining hash register, so multi-block messages can be processed. It can retire 1, 2 or 4 rounds per cycle and streams the final digest one word at a time over a second valid/ready interface toward the output packer. SHA-224 support is optional and compile-time selectable.

## Interface
- UNROLL, 1, rounds per accepted beat; legal values are 1, 2 and 4.
- One clock `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- w_valid  in  1  schedule beat available.
- w_ready  out  1  core accepts a beat.
- w_data  in  32*UNROLL  bits [32i+31:32i] carry W[t+i].
- blk_first  in  1  sampled on the first beat of a block. 1 means initialise from the IV. 0 means chain from the H register.
- blk_last  in  1  sampled on the first beat of a block. 1 means emit the digest after the block.
- mode_224  in  1  sampled on the first beat when blk_first=1; present only with SHA224_EN.
- h_valid  out  1  digest word valid.
- h_ready  in  1  downstream accepts a digest word.
- h_data  out  32  digest word, H0 first.
- h_last  out  1  marks the final digest word.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ROUND, FINAL, OUT.
- IDLE
  - w_ready=1.
  - On a w_valid&w_ready beat, latch blk_first, blk_last and mode.
  - Initial vars are the IV (SHA-256, or SHA-224 if mode=1) when blk_first=1, otherwise the current H0..H7.
  - The round function is applied to those initial vars for rounds 0..UNROLL-1 in the same cycle. The result goes to a..h, t <= UNROLL, and the state moves to ROUND.
- ROUND
  - w_ready=1. Each accepted beat applies UNROLL chained rounds using K[t..t+UNROLL-1], then t += UNROLL.
  - w_valid=0 holds all state (stall).
  - The beat covering round 63 moves the state to FINAL.
- FINAL
  - Lasts one cycle. Hi <= Hi + var_i for all eight words, mod 2^32. The init selection is used as Hi when blk_first=1.
  - Next state is OUT if blk_last=1, otherwise IDLE.
- OUT
  - h_valid=1, h_data=H[idx].
  - idx advances on each h_valid&h_ready beat.
  - Word count is 8 for SHA-256 and 7 for SHA-224 (H0..H6).
  - h_last=1 on the final word; that word's handshake returns the state to IDLE.
- Arithmetic is 32-bit modular and all carries are dropped. Σ0, Σ1, Ch and Maj are per FIPS 180-4. K is a 64-entry constant ROM.
- Boundaries
  - blk_first=0 directly after reset chains from the reset value of H, which is the SHA-256 IV.
  - mode_224 is ignored when blk_first=0; the mode of the message stays in force.
  - w_data is ignored outside accepted beats.
  - An h_ready stall holds h_data and h_last stable.
  - w_ready=0 in FINAL and OUT. The next block cannot start until the digest is drained.
  - Reset mid-block or mid-output aborts: state=IDLE, t=0, idx=0, H=SHA-256 IV, mode=256.

## Timing
- Output values while rst is high and in the cycle after: w_ready=1 (state IDLE), h_valid=0, h_data=0, h_last=0, busy=0.
- h_data=0 whenever h_valid=0.
- A block with no stalls takes 64/UNROLL accepted beats plus 1 FINAL cycle.
- First h_valid is the cycle after FINAL. An 8-word digest with h_ready=1 takes 8 cycles.
- Back-to-back chaining block (blk_last=0): the next first beat is accepted 1 cycle after the last round beat, i.e. the FINAL cycle only.
- The critical path is UNROLL chained rounds.

## Configuration
- SHA224_EN defined:
  - The mode_224 port exists.
  - The SHA-224 IV (c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4) is selectable.
  - Output is 7 words in SHA-224 mode.
- SHA224_EN undefined:
  - No mode_224 port.
  - SHA-256 only; 8 output words always.

## Test plan
- "abc" single block (blk_first=1, blk_last=1), UNROLL=1, h_ready=1 -> h_data ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, h_last on word 8, first h_valid 65 cycles after the first beat.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first=1/last=0, then first=0/last=1) -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; no h_valid after block 1.
- SHA224_EN, mode_224=1, "abc" -> 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, h_last on word 7.
- "abc" with w_valid dropped for 3 cycles at rounds 10 and 40, and h_ready low for 5 cycles on word 3 -> same digest as the first scenario; h_data and h_last stable during the stall.
- rst pulsed at round 30 of a block, then "abc" -> no digest from the aborted block; "abc" digest correct.
- UNROLL=2 and UNROLL=4 running the first two scenarios -> identical digests; the block takes 32 and 16 beats respectively.
